dram_byte_port: RTL and testbench

- Serves the unified byte-wide memory interface (mem_req/mem_addr/mem_rdata/mem_valid) driven by load_execution. Sits directly upstream of it.
- Each byte request becomes a word-wide read on the backing DRAM port.
- A single-word line buffer returns bytes in the same word without another DRAM access. Sequential byte walks in load_v/load_m therefore cost one DRAM read per word.
- Provides invalidate for future store paths and hit/miss counters for profiling.

---
 rtl/dram_byte_port.sv | 198 +++++++++++++++++++
 tb/tb_dram_byte_port.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_byte_port.sv
// dram_byte_port: serves byte reads from a word-wide DRAM read port.
// A single-word line buffer answers further bytes of the same word without
// touching DRAM. The saturating hit/miss counters are for profiling.
module dram_byte_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 24,
    parameter int WORD_WIDTH = 32,
    parameter int OFF_BITS   = $clog2(WORD_WIDTH / DATA_WIDTH),
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_req,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         mem_valid,
    output logic                         dram_rd_en,
    output logic [ADDR_WIDTH-OFF_BITS-1:0] dram_rd_addr,
    input  logic [WORD_WIDTH-1:0]        dram_rd_data,
    input  logic                         dram_rd_valid,
    input  logic                         invalidate,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         hit_count,
    output logic [CNT_WIDTH-1:0]         miss_count
);

    localparam int WADDR_W = ADDR_WIDTH - OFF_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_line_valid;
    logic [WADDR_W-1:0]      r_line_tag;
    logic [WORD_WIDTH-1:0]   r_line_data;
    logic [WADDR_W-1:0]      r_req_waddr;
    logic [OFF_BITS-1:0]     r_req_lane;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [CNT_WIDTH-1:0]    r_hit_cnt;
    logic [CNT_WIDTH-1:0]    r_miss_cnt;

    logic [WADDR_W-1:0]      w_word_addr;
    logic [OFF_BITS-1:0]     w_lane;
    logic                    w_hit;
    logic                    w_take_hit;
    logic                    w_take_miss;
    logic                    w_fill;

    // Little-endian lane pick: lane 0 is the least significant byte of the word.
    function automatic logic [DATA_WIDTH-1:0] lane_select(
        input logic [WORD_WIDTH-1:0] word,
        input logic [OFF_BITS-1:0]   lane
    );
        return word[int'(lane) * DATA_WIDTH +: DATA_WIDTH];
    endfunction

    assign w_word_addr = mem_addr[ADDR_WIDTH-1:OFF_BITS];
    assign w_lane      = mem_addr[OFF_BITS-1:0];
    // A same-cycle invalidate wins over a tag match, so the request goes to DRAM.
    assign w_hit       = r_line_valid && (r_line_tag == w_word_addr) && !invalidate;

    // Every output is either a register or a decode of the state register.
    assign mem_rdata    = r_rdata;
    assign mem_valid    = (r_state == S_RESP);
    assign dram_rd_en   = (r_state == S_FETCH);
    assign dram_rd_addr = r_req_waddr;
    assign busy         = (r_state != S_IDLE);
    assign hit_count    = r_hit_cnt;
    assign miss_count   = r_miss_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the per-cycle action strobes.
    always_comb begin
        w_next_state = r_state;
        w_take_hit   = 1'b0;
        w_take_miss  = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    if (w_hit) begin
                        w_next_state = S_RESP;
                        w_take_hit   = 1'b1;
                    end else begin
                        w_next_state = S_FETCH;
                        w_take_miss  = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FETCH: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (dram_rd_valid) begin
                    w_next_state = S_RESP;
                    w_fill       = 1'b1;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_RESP: begin
                // The request is deliberately not sampled here, so a held request
                // gets exactly one response per round trip.
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Latch the requested word address and lane when a miss starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_waddr <= {WADDR_W{1'b0}};
            r_req_lane  <= {OFF_BITS{1'b0}};
        end else if (w_take_miss) begin
            r_req_waddr <= w_word_addr;
            r_req_lane  <= w_lane;
        end else begin
            r_req_waddr <= r_req_waddr;
            r_req_lane  <= r_req_lane;
        end
    end

    // Line buffer: fill on DRAM return. Invalidate always clears the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_valid <= 1'b0;
            r_line_tag   <= {WADDR_W{1'b0}};
            r_line_data  <= {WORD_WIDTH{1'b0}};
        end else begin
            if (w_fill) begin
                r_line_tag  <= r_req_waddr;
                r_line_data <= dram_rd_data;
            end else begin
                r_line_tag  <= r_line_tag;
                r_line_data <= r_line_data;
            end
            if (invalidate) begin
                r_line_valid <= 1'b0;
            end else if (w_fill) begin
                r_line_valid <= 1'b1;
            end else begin
                r_line_valid <= r_line_valid;
            end
        end
    end

    // Returned byte: taken from the line on a hit, or from the DRAM word on a fill.
    // It holds its value between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= {DATA_WIDTH{1'b0}};
        end else if (w_take_hit) begin
            r_rdata <= lane_select(r_line_data, w_lane);
        end else if (w_fill) begin
            r_rdata <= lane_select(dram_rd_data, r_req_lane);
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Saturating hit/miss counters: they stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= {CNT_WIDTH{1'b0}};
            r_miss_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_take_hit && (r_hit_cnt != {CNT_WIDTH{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_hit_cnt <= r_hit_cnt;
            end
            if (w_take_miss && (r_miss_cnt != {CNT_WIDTH{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_miss_cnt <= r_miss_cnt;
            end
        end
    end

endmodule

// File: tb/tb_dram_byte_port.sv
// Scoreboard bench for dram_byte_port. Each request pushes its expected byte,
// and on a miss its expected DRAM word address. Monitors pop and compare these
// whenever the DUT strobes mem_valid or dram_rd_en.
module tb_dram_byte_port;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic        dram_rd_en;
    logic [21:0] dram_rd_addr;
    logic [31:0] dram_rd_data;
    logic        dram_rd_valid;
    logic        invalidate;
    logic        busy;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        inv_main;
    logic        inv_resp;
    assign invalidate = inv_main | inv_resp;

    int n_checks = 0;
    int n_fail   = 0;
    int resp_lat = 3;
    bit resp_inv = 1'b0;

    logic [7:0]  exp_bytes[$];
    logic [21:0] exp_rd[$];

    dram_byte_port dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_valid     (mem_valid),
        .dram_rd_en    (dram_rd_en),
        .dram_rd_addr  (dram_rd_addr),
        .dram_rd_data  (dram_rd_data),
        .dram_rd_valid (dram_rd_valid),
        .invalidate    (invalidate),
        .busy          (busy),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory contents, written out by hand.
    function automatic logic [31:0] mem_word(input logic [21:0] wa);
        case (wa)
            22'h000040: return 32'h44332211;
            22'h000041: return 32'h88776655;
            22'h000080: return 32'hDDCCBBAA;
            default:    return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pop the expected byte on every mem_valid and check it
    // never follows another mem_valid directly.
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        if (mem_valid === 1'b1) begin
            if (exp_bytes.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mem_valid: got rdata 0x%0h expected no response", mem_rdata);
            end else begin
                check("mem_rdata", {24'h0, mem_rdata}, {24'h0, exp_bytes.pop_front()});
            end
            check("no_back_to_back", {31'h0, prev_valid}, 32'h0);
        end
        prev_valid = (mem_valid === 1'b1);
    end

    // DRAM command monitor: every read strobe must match an expected word address.
    always @(negedge clk) begin
        if (dram_rd_en === 1'b1) begin
            if (exp_rd.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dram_rd: got addr 0x%0h expected no read", dram_rd_addr);
            end else begin
                check("dram_rd_addr", {10'h0, dram_rd_addr}, {10'h0, exp_rd.pop_front()});
            end
        end
    end

    // DRAM responder: answers each read resp_lat cycles later. It can raise
    // invalidate in the same cycle as the data strobe.
    initial begin
        logic [21:0] wa;
        dram_rd_valid = 1'b0;
        dram_rd_data  = 32'h0;
        inv_resp      = 1'b0;
        forever begin
            @(negedge clk);
            if (dram_rd_en === 1'b1) begin
                wa = dram_rd_addr;
                repeat (resp_lat) @(posedge clk);
                #1;
                dram_rd_valid = 1'b1;
                dram_rd_data  = mem_word(wa);
                inv_resp      = resp_inv;
                @(posedge clk);
                #1;
                dram_rd_valid = 1'b0;
                inv_resp      = 1'b0;
            end
        end
    end

    // One request/response round trip. Expected latency is counted in cycles
    // from the first sampling edge until mem_valid is visible.
    task automatic do_req(input logic [23:0] a, input logic [7:0] exp_b,
                          input bit miss, input bit with_inv, input int exp_lat);
        int lat;
        bit seen;
        exp_bytes.push_back(exp_b);
        if (miss) exp_rd.push_back(a[23:2]);
        mem_req  = 1'b1;
        mem_addr = a;
        inv_main = with_inv;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 50) begin
            @(posedge clk);
            #1;
            inv_main = 1'b0;
            lat++;
            if (mem_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got no mem_valid for addr 0x%0h expected one within 50 cycles", a);
        end else begin
            check("latency", lat, exp_lat);
        end
        @(posedge clk);
        #1;
        mem_req = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_mem_valid"},  {31'h0, mem_valid}, 32'h0);
        check({tag, "_dram_rd_en"}, {31'h0, dram_rd_en}, 32'h0);
        check({tag, "_busy"},       {31'h0, busy}, 32'h0);
        check({tag, "_hit_count"},  hit_count, 32'h0);
        check({tag, "_miss_count"}, miss_count, 32'h0);
    endtask

    initial begin
        int cyc;
        int last;
        int pulses;
        rst_n    = 1'b0;
        mem_req  = 1'b0;
        mem_addr = 24'h0;
        inv_main = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        check("reset_mem_rdata",    {24'h0, mem_rdata}, 32'h0);
        check("reset_dram_rd_addr", {10'h0, dram_rd_addr}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, followed by sequential hits within the same word.
        do_req(24'h000100, 8'h11, 1'b1, 1'b0, 5);
        check("miss_after_first", miss_count, 32'd1);
        check("hit_after_first",  hit_count, 32'd0);
        do_req(24'h000101, 8'h22, 1'b0, 1'b0, 1);
        do_req(24'h000102, 8'h33, 1'b0, 1'b0, 1);
        do_req(24'h000103, 8'h44, 1'b0, 1'b0, 1);
        check("hit_after_walk",  hit_count, 32'd3);
        check("miss_after_walk", miss_count, 32'd1);

        // Moving to the next word misses.
        do_req(24'h000104, 8'h55, 1'b1, 1'b0, 5);
        check("miss_next_word", miss_count, 32'd2);

        // Reload tag 0x40, then invalidate alongside a request that would hit.
        do_req(24'h000100, 8'h11, 1'b1, 1'b0, 5);
        resp_inv = 1'b1;
        do_req(24'h000101, 8'h22, 1'b1, 1'b1, 5);
        resp_inv = 1'b0;
        // Invalidate arrived with the fill, so the next access to this word misses too.
        do_req(24'h000102, 8'h33, 1'b1, 1'b0, 5);
        do_req(24'h000103, 8'h44, 1'b0, 1'b0, 1);
        check("miss_after_inv", miss_count, 32'd5);
        check("hit_after_inv",  hit_count, 32'd4);

        // Hold mem_req high: one pulse per round trip, with a one-cycle gap between pulses.
        exp_bytes.push_back(8'hAA);
        exp_bytes.push_back(8'hAA);
        exp_bytes.push_back(8'hAA);
        exp_rd.push_back(22'h000080);
        mem_req  = 1'b1;
        mem_addr = 24'h000200;
        cyc = 0;
        last = 0;
        pulses = 0;
        while (pulses < 3 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_valid === 1'b1) begin
                pulses++;
                if (pulses > 1) check("held_req_gap", cyc - last, 32'd2);
                last = cyc;
            end
        end
        check("held_req_pulses", pulses, 32'd3);
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        check("miss_after_hold", miss_count, 32'd6);
        check("hit_after_hold",  hit_count, 32'd6);

        // Reset during WAIT. The late DRAM strobe must be ignored.
        resp_lat = 6;
        exp_rd.push_back(22'h0000C0);
        mem_req  = 1'b1;
        mem_addr = 24'h000300;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("busy_in_wait", {31'h0, busy}, 32'h1);
        rst_n   = 1'b0;
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        check_idle_zero("midreset");
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check_idle_zero("after_late_valid");
        // The line must still be empty, so the same word misses again.
        resp_lat = 3;
        do_req(24'h000300, 8'hEF, 1'b1, 1'b0, 5);
        check("miss_post_reset", miss_count, 32'd1);
        check("hit_post_reset",  hit_count, 32'd0);

        repeat (5) @(posedge clk);
        #1;
        check("bytes_queue_empty", exp_bytes.size(), 32'd0);
        check("rd_queue_empty",    exp_rd.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
